// File: rtl/nf1g_reg_ring_master.sv
// Register-ring master: launches one host transaction into the ring and terminates it on return.
// A timed-out transaction is followed by a drain window so a late return cannot complete the next one.
module nf1g_reg_ring_master #(
    parameter int C_RBS_ADDR_WIDTH = 32,
    parameter int C_RBS_DATA_WIDTH = 32,
    parameter int C_RBS_SRC_WIDTH  = 2,
    parameter int C_SRC_ID         = 0,
    parameter int C_TIMEOUT        = 1023
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic                          HOST_REQ,
    input  logic                          HOST_RD_WR_L,
    input  logic [C_RBS_ADDR_WIDTH-3:0]   HOST_ADDR,
    input  logic [C_RBS_DATA_WIDTH-1:0]   HOST_WDATA,
    output logic                          HOST_BUSY,
    output logic                          HOST_DONE,
    output logic                          HOST_ERR,
    output logic [C_RBS_DATA_WIDTH-1:0]   HOST_RDATA,
    output logic                          M_RBS_REQ,
    output logic                          M_RBS_ACK,
    output logic                          M_RBS_RD_WR_L,
    output logic [C_RBS_ADDR_WIDTH-3:0]   M_RBS_ADDR,
    output logic [C_RBS_DATA_WIDTH-1:0]   M_RBS_DATA,
    output logic [C_RBS_SRC_WIDTH-1:0]    M_RBS_SRC,
    input  logic                          S_RBS_REQ,
    input  logic                          S_RBS_ACK,
    input  logic                          S_RBS_RD_WR_L,
    input  logic [C_RBS_ADDR_WIDTH-3:0]   S_RBS_ADDR,
    input  logic [C_RBS_DATA_WIDTH-1:0]   S_RBS_DATA,
    input  logic [C_RBS_SRC_WIDTH-1:0]    S_RBS_SRC
);

    localparam int AW = C_RBS_ADDR_WIDTH - 2;
    localparam int DW = C_RBS_DATA_WIDTH;
    localparam int SW = C_RBS_SRC_WIDTH;
    localparam int CW = $clog2(C_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [SW-1:0] SRC_ID   = SW'(C_SRC_ID);
    localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            m_req_q, m_req_d;
    logic            m_rd_q, m_rd_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic [SW-1:0]   m_src_q, m_src_d;
    logic            match;
    logic            cnt_last;

    // The launched address/direction registers double as the latched transaction.
    assign match    = S_RBS_REQ && (S_RBS_SRC == SRC_ID) &&
                      (S_RBS_ADDR == m_addr_q) && (S_RBS_RD_WR_L == m_rd_q);
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (HOST_REQ) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (match) state_d = IDLE;
                     else if (cnt_last) state_d = DRAIN;
            DRAIN:   if (cnt_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = (state_d != IDLE);
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        m_req_d  = 1'b0;
        m_rd_d   = m_rd_q;
        m_addr_d = m_addr_q;
        m_data_d = m_data_q;
        m_src_d  = m_src_q;
        case (state_q)
            IDLE: begin
                if (HOST_REQ) begin
                    m_req_d  = 1'b1;
                    m_rd_d   = HOST_RD_WR_L;
                    m_addr_d = HOST_ADDR;
                    m_data_d = HOST_RD_WR_L ? '0 : HOST_WDATA;
                    m_src_d  = SRC_ID;
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                if (match) begin
                    done_d = 1'b1;
                    err_d  = ~S_RBS_ACK;
                    if (m_rd_q) rdata_d = S_RBS_ACK ? S_RBS_DATA : ERR_DATA;
                end else if (cnt_last) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: if (!cnt_last && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            m_req_q  <= 1'b0;
            m_rd_q   <= 1'b0;
            m_addr_q <= '0;
            m_data_q <= '0;
            m_src_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            m_req_q  <= m_req_d;
            m_rd_q   <= m_rd_d;
            m_addr_q <= m_addr_d;
            m_data_q <= m_data_d;
            m_src_q  <= m_src_d;
        end
    end

    assign HOST_BUSY     = busy_q;
    assign HOST_DONE     = done_q;
    assign HOST_ERR      = err_q;
    assign HOST_RDATA    = rdata_q;
    assign M_RBS_REQ     = m_req_q;
    assign M_RBS_ACK     = 1'b0;
    assign M_RBS_RD_WR_L = m_rd_q;
    assign M_RBS_ADDR    = m_addr_q;
    assign M_RBS_DATA    = m_data_q;
    assign M_RBS_SRC     = m_src_q;

endmodule

// File: tb/tb_nf1g_reg_ring_master.sv
// Directed bench: DUT closed through a 3-stage ring model whose middle stage is a stub register node.
module tb_nf1g_reg_ring_master;

    typedef struct packed {
        logic        req;
        logic        ack;
        logic        rd;
        logic [29:0] addr;
        logic [31:0] data;
        logic [1:0]  src;
    } rbs_t;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        HOST_REQ, HOST_RD_WR_L;
    logic [29:0] HOST_ADDR;
    logic [31:0] HOST_WDATA;
    logic        HOST_BUSY, HOST_DONE, HOST_ERR;
    logic [31:0] HOST_RDATA;
    logic        M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L;
    logic [29:0] M_RBS_ADDR;
    logic [31:0] M_RBS_DATA;
    logic [1:0]  M_RBS_SRC;
    logic        S_RBS_REQ, S_RBS_ACK, S_RBS_RD_WR_L;
    logic [29:0] S_RBS_ADDR;
    logic [31:0] S_RBS_DATA;
    logic [1:0]  S_RBS_SRC;

    rbs_t        m_bus, st1, st2, st3, inj, s_bus;
    logic        inj_en, ring_open;
    logic [31:0] reg10;
    int          checks, errors, done_cnt, req_cnt;

    always #5 CLK = ~CLK;

    nf1g_reg_ring_master #(.C_SRC_ID(1), .C_TIMEOUT(8)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .HOST_REQ(HOST_REQ), .HOST_RD_WR_L(HOST_RD_WR_L), .HOST_ADDR(HOST_ADDR),
        .HOST_WDATA(HOST_WDATA), .HOST_BUSY(HOST_BUSY), .HOST_DONE(HOST_DONE),
        .HOST_ERR(HOST_ERR), .HOST_RDATA(HOST_RDATA),
        .M_RBS_REQ(M_RBS_REQ), .M_RBS_ACK(M_RBS_ACK), .M_RBS_RD_WR_L(M_RBS_RD_WR_L),
        .M_RBS_ADDR(M_RBS_ADDR), .M_RBS_DATA(M_RBS_DATA), .M_RBS_SRC(M_RBS_SRC),
        .S_RBS_REQ(S_RBS_REQ), .S_RBS_ACK(S_RBS_ACK), .S_RBS_RD_WR_L(S_RBS_RD_WR_L),
        .S_RBS_ADDR(S_RBS_ADDR), .S_RBS_DATA(S_RBS_DATA), .S_RBS_SRC(S_RBS_SRC)
    );

    // Ring model: stage1 register, stub node (claims 0x10 as R/W reg, 0x20 read-only), stage3 register.
    assign m_bus = {M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L, M_RBS_ADDR, M_RBS_DATA, M_RBS_SRC};
    assign s_bus = inj_en ? inj : st3;
    assign {S_RBS_REQ, S_RBS_ACK, S_RBS_RD_WR_L, S_RBS_ADDR, S_RBS_DATA, S_RBS_SRC} = s_bus;

    always_ff @(posedge CLK) begin
        st1 <= ring_open ? '0 : m_bus;
        st2 <= st1;
        if (st1.req && st1.addr == 30'h10) begin
            st2.ack <= 1'b1;
            if (st1.rd) st2.data <= reg10;
            else        reg10    <= st1.data;
        end else if (st1.req && st1.addr == 30'h20 && st1.rd) begin
            st2.ack  <= 1'b1;
            st2.data <= 32'h1234_5678;
        end
        st3 <= st2;
    end

    always @(negedge CLK) begin
        if (HOST_DONE === 1'b1) done_cnt++;
        if (M_RBS_REQ === 1'b1) req_cnt++;
    end

    task automatic issue(input logic rd, input logic [29:0] addr, input logic [31:0] wdata);
        HOST_REQ = 1'b1; HOST_RD_WR_L = rd; HOST_ADDR = addr; HOST_WDATA = wdata;
        @(posedge CLK); #1;
        HOST_REQ = 1'b0;
    endtask

    // Returns the number of edges since the request edge at which HOST_DONE is seen (40 = never).
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (HOST_DONE !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        RESETN = 1'b1;
        #2 RESETN = 1'b0;
        #1;
        checks++;
        if ({HOST_BUSY, HOST_DONE, HOST_ERR, HOST_RDATA, M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L,
             M_RBS_ADDR, M_RBS_DATA, M_RBS_SRC} !== '0) begin
            errors++; $display("FAIL reset_outputs: busy=%b done=%b rdata=%h m_req=%b m_addr=%h expected all zero",
                               HOST_BUSY, HOST_DONE, HOST_RDATA, M_RBS_REQ, M_RBS_ADDR);
        end
        repeat (2) @(posedge CLK);
        #1 RESETN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_write;
        int lat;
        issue(1'b0, 30'h10, 32'hA5A5_0001);
        checks++;
        if ({M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L} !== 3'b100 || M_RBS_DATA !== 32'hA5A5_0001 ||
            M_RBS_SRC !== 2'd1 || M_RBS_ADDR !== 30'h10 || HOST_BUSY !== 1'b1) begin
            errors++; $display("FAIL write_launch: req/ack/rd=%b data=%h src=%0d addr=%h busy=%b expected 100 a5a50001 1 10 1",
                               {M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L}, M_RBS_DATA, M_RBS_SRC, M_RBS_ADDR, HOST_BUSY);
        end
        wait_done(0, lat);
        checks++;
        if (lat !== 4 || HOST_ERR !== 1'b0 || HOST_BUSY !== 1'b0 || HOST_RDATA !== 32'h0) begin
            errors++; $display("FAIL write_done: lat=%0d err=%b busy=%b rdata=%h expected 4 0 0 0",
                               lat, HOST_ERR, HOST_BUSY, HOST_RDATA);
        end
        @(posedge CLK); #1;
        checks++;
        if (HOST_DONE !== 1'b0 || M_RBS_REQ !== 1'b0 || M_RBS_DATA !== 32'hA5A5_0001 || req_cnt !== 1) begin
            errors++; $display("FAIL write_after: done=%b m_req=%b m_data=%h req_cnt=%0d expected 0 0 a5a50001 1",
                               HOST_DONE, M_RBS_REQ, M_RBS_DATA, req_cnt);
        end
    endtask

    task automatic test_unclaimed;
        int lat;
        issue(1'b1, 30'h3FF, 32'hFFFF_FFFF);
        checks++;
        if (M_RBS_DATA !== 32'h0 || M_RBS_RD_WR_L !== 1'b1) begin
            errors++; $display("FAIL read_launch_data: data=%h rd=%b expected 0 1", M_RBS_DATA, M_RBS_RD_WR_L);
        end
        wait_done(0, lat);
        checks++;
        if (lat !== 4 || HOST_ERR !== 1'b1 || HOST_RDATA !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL unclaimed: lat=%0d err=%b rdata=%h expected 4 1 deadbeef", lat, HOST_ERR, HOST_RDATA);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_read;
        int lat;
        issue(1'b1, 30'h20, 32'h0);
        wait_done(0, lat);
        checks++;
        if (lat !== 4 || HOST_ERR !== 1'b0 || HOST_RDATA !== 32'h1234_5678) begin
            errors++; $display("FAIL read_20: lat=%0d err=%b rdata=%h expected 4 0 12345678", lat, HOST_ERR, HOST_RDATA);
        end
        @(posedge CLK); #1;
        issue(1'b0, 30'h10, 32'hA5A5_0001);
        wait_done(0, lat);
        checks++;
        if (lat !== 4 || HOST_ERR !== 1'b0 || HOST_RDATA !== 32'h1234_5678) begin
            errors++; $display("FAIL write_keeps_rdata: lat=%0d err=%b rdata=%h expected 4 0 12345678", lat, HOST_ERR, HOST_RDATA);
        end
        @(posedge CLK); #1;
        issue(1'b1, 30'h10, 32'h0);
        wait_done(0, lat);
        checks++;
        if (lat !== 4 || HOST_ERR !== 1'b0 || HOST_RDATA !== 32'hA5A5_0001) begin
            errors++; $display("FAIL read_10: lat=%0d err=%b rdata=%h expected 4 0 a5a50001", lat, HOST_ERR, HOST_RDATA);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_timeout;
        int lat, d0;
        ring_open = 1'b1;
        issue(1'b1, 30'h40, 32'h0);
        wait_done(0, lat);
        checks++;
        if (lat !== 9 || HOST_ERR !== 1'b1 || HOST_RDATA !== 32'hA5A5_0001 || HOST_BUSY !== 1'b1) begin
            errors++; $display("FAIL timeout_done: lat=%0d err=%b rdata=%h busy=%b expected 9 1 a5a50001 1",
                               lat, HOST_ERR, HOST_RDATA, HOST_BUSY);
        end
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (HOST_BUSY !== 1'b1) begin
                errors++; $display("FAIL drain_busy[%0d]: busy=%b expected 1", i, HOST_BUSY);
            end
            inj_en = (i == 2);
            inj = '{req: 1'b1, ack: 1'b1, rd: 1'b1, addr: 30'h40, data: 32'h0BAD_0BAD, src: 2'd1};
            @(posedge CLK); #1;
        end
        inj_en = 1'b0;
        checks++;
        if (HOST_BUSY !== 1'b0 || HOST_DONE !== 1'b0 || done_cnt !== d0 + 1 || HOST_RDATA !== 32'hA5A5_0001) begin
            errors++; $display("FAIL drain_end: busy=%b done=%b dones=%0d rdata=%h expected 0 0 %0d a5a50001",
                               HOST_BUSY, HOST_DONE, done_cnt, HOST_RDATA, d0 + 1);
        end
        ring_open = 1'b0;
        issue(1'b1, 30'h20, 32'h0);
        wait_done(0, lat);
        checks++;
        if (lat !== 4 || HOST_ERR !== 1'b0 || HOST_RDATA !== 32'h1234_5678) begin
            errors++; $display("FAIL after_timeout: lat=%0d err=%b rdata=%h expected 4 0 12345678", lat, HOST_ERR, HOST_RDATA);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_stray;
        int lat, d0, r0;
        d0 = done_cnt; r0 = req_cnt;
        HOST_RDATA_prep: begin end
        issue(1'b1, 30'h10, 32'h0);
        @(posedge CLK); #1;
        inj_en = 1'b1;
        inj = '{req: 1'b1, ack: 1'b1, rd: 1'b1, addr: 30'h10, data: 32'h5555_5555, src: 2'd2};
        HOST_REQ = 1'b1; HOST_RD_WR_L = 1'b0; HOST_ADDR = 30'h10; HOST_WDATA = 32'h9999_9999;
        @(posedge CLK); #1;
        inj.src = 2'd1; inj.addr = 30'h11;
        @(posedge CLK); #1;
        inj_en = 1'b0; HOST_REQ = 1'b0;
        checks++;
        if (HOST_DONE !== 1'b0 || HOST_BUSY !== 1'b1) begin
            errors++; $display("FAIL stray_ignored: done=%b busy=%b expected 0 1", HOST_DONE, HOST_BUSY);
        end
        wait_done(3, lat);
        checks++;
        if (lat !== 4 || HOST_ERR !== 1'b0 || HOST_RDATA !== 32'hA5A5_0001) begin
            errors++; $display("FAIL stray_done: lat=%0d err=%b rdata=%h expected 4 0 a5a50001", lat, HOST_ERR, HOST_RDATA);
        end
        repeat (6) @(posedge CLK);
        #1;
        checks++;
        if (done_cnt !== d0 + 1 || req_cnt !== r0 + 1 || HOST_BUSY !== 1'b0) begin
            errors++; $display("FAIL stray_counts: dones=%0d reqs=%0d busy=%b expected %0d %0d 0",
                               done_cnt - d0, req_cnt - r0, HOST_BUSY, 1, 1);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = done_cnt;
        issue(1'b1, 30'h20, 32'h0);
        @(posedge CLK); #1;
        RESETN = 1'b0;
        #1;
        checks++;
        if (HOST_BUSY !== 1'b0 || HOST_RDATA !== 32'h0 || M_RBS_ADDR !== 30'h0 || M_RBS_SRC !== 2'd0 ||
            M_RBS_RD_WR_L !== 1'b0) begin
            errors++; $display("FAIL reset_async: busy=%b rdata=%h m_addr=%h m_src=%0d m_rd=%b expected all zero",
                               HOST_BUSY, HOST_RDATA, M_RBS_ADDR, M_RBS_SRC, M_RBS_RD_WR_L);
        end
        @(posedge CLK); #2;
        RESETN = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        checks++;
        if (done_cnt !== d0 || HOST_BUSY !== 1'b0 || HOST_RDATA !== 32'h0) begin
            errors++; $display("FAIL reset_no_done: dones=%0d busy=%b rdata=%h expected %0d 0 0",
                               done_cnt, HOST_BUSY, HOST_RDATA, d0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0; req_cnt = 0;
        reg10 = 32'h0; st1 = '0; st2 = '0; st3 = '0;
        inj = '0; inj_en = 1'b0; ring_open = 1'b0;
        HOST_REQ = 1'b0; HOST_RD_WR_L = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
        test_reset;
        test_write;
        test_unclaimed;
        test_read;
        test_timeout;
        test_stray;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
